// File: rtl/umi_pkg.sv
// umi_pkg: shared UMI command-word layout (opcode, size, options offsets),
// the opcode write bit, and the state type of the packet builder.
package umi_pkg;

    // Command word layout: {options[CW-1:12], size[11:8], opcode[7:0]}
    localparam int OPC_LSB       = 0;
    localparam int OPC_W         = 8;
    localparam int OPC_WRITE_BIT = 0;
    localparam int SIZE_LSB      = 8;
    localparam int SIZE_W        = 4;
    localparam int OPT_LSB       = 12;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // log2 of the number of bytes carried by one payload of width_bits
    function automatic int log2_bytes(input int width_bits);
        return $clog2(width_bits / 8);
    endfunction

endpackage

// File: rtl/umi_pack_tx_if.sv
// umi_pack_tx_if: request header, write-data stream and packet egress
// channels of the UMI transmit packet builder.
//
// Handshake rule for all three channels: a transfer happens on a rising
// clock edge where valid and ready are both high; the source holds valid
// and its payload stable until that edge, and ready never depends on the
// same-cycle transfer having already happened.
interface umi_pack_tx_if #(
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int UW = 256
);
    logic                                 req_valid;
    logic                                 req_ready;
    logic [umi_pkg::OPC_W-1:0]            req_opcode;
    logic [umi_pkg::SIZE_W-1:0]           req_tsize;
    logic [CW-umi_pkg::OPT_LSB-1:0]       req_options;
    logic [AW-1:0]                        req_dstaddr;
    logic [AW-1:0]                        req_srcaddr;

    logic                                 data_valid;
    logic                                 data_ready;
    logic [UW-1:0]                        data;

    logic                                 packet_valid;
    logic                                 packet_ready;
    logic [CW-1:0]                        packet_cmd;
    logic [AW-1:0]                        packet_dst_addr;
    logic [AW-1:0]                        packet_src_addr;
    logic [UW-1:0]                        packet_payload;

    // Packet builder side
    modport slave (
        input  req_valid, req_opcode, req_tsize, req_options, req_dstaddr, req_srcaddr,
        output req_ready,
        input  data_valid, data,
        output data_ready,
        output packet_valid, packet_cmd, packet_dst_addr, packet_src_addr, packet_payload,
        input  packet_ready
    );

    // Initiator / fabric side
    modport master (
        output req_valid, req_opcode, req_tsize, req_options, req_dstaddr, req_srcaddr,
        input  req_ready,
        output data_valid, data,
        input  data_ready,
        input  packet_valid, packet_cmd, packet_dst_addr, packet_src_addr, packet_payload,
        output packet_ready
    );
endinterface

// File: rtl/umi_pack.sv
// umi_pack: combinational assembly of a UMI command word from its fields.
module umi_pack import umi_pkg::*; #(
    parameter int CW = 32
) (
    input  logic [OPC_W-1:0]     opcode,
    input  logic [SIZE_W-1:0]    size,
    input  logic [CW-OPT_LSB-1:0] options,
    output logic [CW-1:0]        cmd
);

    // Place each field at its fixed offset in the command word
    always_comb begin
        cmd = '0;
        cmd[OPC_LSB +: OPC_W]       = opcode;
        cmd[SIZE_LSB +: SIZE_W]     = size;
        cmd[OPT_LSB +: CW-OPT_LSB]  = options;
    end

endmodule

// File: rtl/umi_pack_tx.sv
// umi_pack_tx: transmit-side UMI packet builder. Turns a request header
// (plus write beats) into UMI packets; write bursts wider than one payload
// become consecutive full-width packets with an incrementing destination.
// Optional feature macro: UMI_PACK_TX_ALIGN_EN (drop misaligned writes,
// pulse err).
module umi_pack_tx import umi_pkg::*; #(
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int UW = 256
) (
    input  logic          clk,
    input  logic          nreset,
    umi_pack_tx_if.slave  bus,
    output logic          busy,
`ifdef UMI_PACK_TX_ALIGN_EN
    output logic          err,
`endif
    output tx_state_t     dbg_state
);

    localparam int                 PB    = log2_bytes(UW);
    localparam int                 CNTW  = 16 - PB;
    localparam logic [SIZE_W-1:0]  PB_SZ = SIZE_W'(PB);
    localparam logic [AW-1:0]      STEP  = AW'(UW / 8);

    tx_state_t        state_q, state_d;
    logic             wr_q;
    logic [CW-1:0]    cmd_q;
    logic [AW-1:0]    dst_q, src_q;
    logic [CNTW-1:0]  cnt_q;

    logic             pkt_valid_q;
    logic [CW-1:0]    pkt_cmd_q;
    logic [AW-1:0]    pkt_dst_q, pkt_src_q;
    logic [UW-1:0]    pkt_payload_q;

    logic             hdr_write, hdr_big, hdr_acc, hdr_drop;
    logic [SIZE_W-1:0] hdr_size;
    logic [CW-1:0]    hdr_cmd;
    logic [CNTW-1:0]  hdr_beats;
    logic             load_ok, rd_bypass, rd_send, beat_acc, pkt_load;

    assign hdr_write = bus.req_opcode[OPC_WRITE_BIT];
    assign hdr_big   = hdr_write && (bus.req_tsize > PB_SZ);
    // Writes carry at most one payload per packet; reads report the full size
    assign hdr_size  = hdr_big ? PB_SZ : bus.req_tsize;
    assign hdr_beats = hdr_big ? (CNTW'(1) << (bus.req_tsize - PB_SZ)) : CNTW'(1);

    umi_pack #(.CW(CW)) u_pack (
        .opcode  (bus.req_opcode),
        .size    (hdr_size),
        .options (bus.req_options),
        .cmd     (hdr_cmd)
    );

    assign load_ok   = !pkt_valid_q || bus.packet_ready;
    assign hdr_acc   = bus.req_valid && (state_q == IDLE);
    // A read arriving while the output register is free is emitted directly
    assign rd_bypass = hdr_acc && !hdr_write && load_ok;
    assign rd_send   = (state_q == SEND) && !wr_q && load_ok;
    assign beat_acc  = (state_q == SEND) && wr_q && load_ok && bus.data_valid;
    assign pkt_load  = rd_bypass || rd_send || beat_acc;

`ifdef UMI_PACK_TX_ALIGN_EN
    logic [AW-1:0] align_mask;
    // Alignment unit is min(2^tsize, UW/8) bytes, which is 2^hdr_size for writes
    assign align_mask = (AW'(1) << hdr_size) - AW'(1);
    assign hdr_drop   = hdr_acc && hdr_write && (|(bus.req_dstaddr & align_mask));
`else
    assign hdr_drop   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake readies
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = (state_q == IDLE);
        bus.data_ready = (state_q == SEND) && wr_q && load_ok;
        case (state_q)
            IDLE: if (hdr_acc && !hdr_drop && (hdr_write || !load_ok)) state_d = SEND;
            SEND: if (rd_send || (beat_acc && cnt_q == CNTW'(1)))     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request context: latched at header accept, address and count step per beat
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q  <= 1'b0;
            cmd_q <= '0;
            dst_q <= '0;
            src_q <= '0;
            cnt_q <= '0;
        end else if (hdr_acc) begin
            wr_q  <= hdr_write;
            cmd_q <= hdr_cmd;
            dst_q <= bus.req_dstaddr;
            src_q <= bus.req_srcaddr;
            cnt_q <= (hdr_drop || rd_bypass) ? '0 : hdr_beats;
        end else if (beat_acc) begin
            dst_q <= dst_q + STEP;
            cnt_q <= cnt_q - CNTW'(1);
        end else if (rd_send) begin
            cnt_q <= '0;
        end
    end

    // Output register: load when empty or draining, otherwise hold
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pkt_valid_q   <= 1'b0;
            pkt_cmd_q     <= '0;
            pkt_dst_q     <= '0;
            pkt_src_q     <= '0;
            pkt_payload_q <= '0;
        end else if (pkt_load) begin
            pkt_valid_q   <= 1'b1;
            pkt_cmd_q     <= rd_bypass ? hdr_cmd         : cmd_q;
            pkt_dst_q     <= rd_bypass ? bus.req_dstaddr : dst_q;
            pkt_src_q     <= rd_bypass ? bus.req_srcaddr : src_q;
            pkt_payload_q <= beat_acc  ? bus.data        : '0;
        end else if (bus.packet_ready) begin
            pkt_valid_q   <= 1'b0;
        end
    end

`ifdef UMI_PACK_TX_ALIGN_EN
    // One-cycle pulse for each dropped misaligned write header
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) err <= 1'b0;
        else         err <= hdr_drop;
    end
`endif

    assign bus.packet_valid    = pkt_valid_q;
    assign bus.packet_cmd      = pkt_cmd_q;
    assign bus.packet_dst_addr = pkt_dst_q;
    assign bus.packet_src_addr = pkt_src_q;
    assign bus.packet_payload  = pkt_payload_q;
    assign busy                = (state_q != IDLE) || pkt_valid_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_umi_pack_tx.sv
// tb_umi_pack_tx: directed and randomized requests against umi_pack_tx,
// with packets checked in order against a queue of expected packets.
module tb_umi_pack_tx;
    import umi_pkg::*;

    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int UW    = 256;
    localparam int PB    = 5;
    localparam int W     = CW + 2 * AW + UW;
    localparam int LIMIT = 300;

    logic      clk;
    logic      nreset;
    logic      busy;
    tx_state_t dbg_state;
`ifdef UMI_PACK_TX_ALIGN_EN
    logic      err;
`endif

    umi_pack_tx_if #(.AW(AW), .CW(CW), .UW(UW)) bus ();

    umi_pack_tx #(.AW(AW), .CW(CW), .UW(UW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus.slave),
        .busy      (busy),
`ifdef UMI_PACK_TX_ALIGN_EN
        .err       (err),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    logic [W-1:0] exp_q[$];

    logic [7:0]        cur_op;
    logic [3:0]        cur_ts;
    logic [CW-13:0]    cur_opt;
    logic [AW-1:0]     cur_dst;
    logic [AW-1:0]     cur_src;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_pkt(input logic [7:0] op, input logic [3:0] ts,
                                               input logic [CW-13:0] opt, input logic [AW-1:0] dst,
                                               input logic [AW-1:0] src, input logic [UW-1:0] pay);
        logic [3:0] sz;
        sz = (op[0] && ts > 4'(PB)) ? 4'(PB) : ts;
        return {opt, sz, op, dst, src, pay};
    endfunction

    function automatic int model_beats(input logic [7:0] op, input logic [3:0] ts);
        if (op[0] && int'(ts) > PB) return 1 << (int'(ts) - PB);
        return 1;
    endfunction

    // ---------------- drivers ----------------
    initial begin
        bus.packet_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       bus.packet_ready = ~bus.packet_ready;
                2:       bus.packet_ready = 1'($urandom_range(0, 1));
                default: bus.packet_ready = 1'b1;
            endcase
        end
    end

    // Present a header and hold it until accepted; reads are queued as expected here
    task automatic send_hdr(input logic [7:0] op, input logic [3:0] ts, input logic [CW-13:0] opt,
                            input logic [AW-1:0] dst, input logic [AW-1:0] src);
        int k;
        cur_op = op; cur_ts = ts; cur_opt = opt; cur_dst = dst; cur_src = src;
        bus.req_opcode  = op;
        bus.req_tsize   = ts;
        bus.req_options = opt;
        bus.req_dstaddr = dst;
        bus.req_srcaddr = src;
        bus.req_valid   = 1'b1;
        if (!op[0]) exp_q.push_back(model_pkt(op, ts, opt, dst, src, '0));
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) break;
        end
        check("hdr_timeout", W'(k >= LIMIT), '0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Stream cnt random beats for the current write; stalls = cycles spent waiting
    task automatic send_beats(input int cnt, input bit keep_valid, output int stalls);
        int k;
        logic [UW-1:0] d;
        stalls = 0;
        for (int i = 0; i < cnt; i++) begin
            for (int j = 0; j < UW / 32; j++) d[j*32 +: 32] = $urandom();
            bus.data       = d;
            bus.data_valid = 1'b1;
            exp_q.push_back(model_pkt(cur_op, cur_ts, cur_opt, cur_dst + AW'(i * (UW / 8)), cur_src, d));
            for (k = 0; k < LIMIT; k++) begin
                @(negedge clk);
                if (i > 0 && k == 0) check("wr_latency", W'(bus.packet_valid), W'(1));
                if (bus.data_ready === 1'b1) break;
                stalls++;
            end
            check("beat_timeout", W'(k >= LIMIT), '0);
            @(posedge clk); #1;
        end
        if (!keep_valid) begin
            bus.data_valid = 1'b0;
            @(negedge clk);
            check("wr_latency", W'(bus.packet_valid), W'(1));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.packet_valid === 1'b0) break;
        end
        check("drain", W'(exp_q.size()), '0);
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] held;
    bit           stall_hold = 0;

    always @(negedge clk) begin
        logic [W-1:0] cur;
        cur = {bus.packet_cmd, bus.packet_dst_addr, bus.packet_src_addr, bus.packet_payload};
        if (!nreset) begin
            stall_hold = 0;
        end else begin
            if (stall_hold) begin
                check("stall_valid", W'(bus.packet_valid), W'(1));
                check("stall_stable", cur, held);
            end
            stall_hold = 0;
            if (bus.packet_valid === 1'b1) begin
                if (bus.packet_ready === 1'b1) begin
                    check("pkt_unexpected", W'(exp_q.size() == 0), '0);
                    if (exp_q.size() != 0) check("pkt", cur, exp_q.pop_front());
                end else begin
                    held       = cur;
                    stall_hold = 1;
                    check("dready_stall", W'(bus.data_ready), '0);
                end
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int stalls;
        logic [7:0]  op;
        logic [3:0]  ts;
        logic [AW-1:0] dst;
        int lg;

        nreset = 1'b0;
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_tsize = '0; bus.req_options = '0;
        bus.req_dstaddr = '0; bus.req_srcaddr = '0; bus.data_valid = 1'b0; bus.data = '0;
        repeat (2) @(posedge clk); #1;

        // reset values
        check("rst_req_ready",  W'(bus.req_ready), W'(1));
        check("rst_data_ready", W'(bus.data_ready), '0);
        check("rst_valid",      W'(bus.packet_valid), '0);
        check("rst_fields",     {bus.packet_cmd, bus.packet_dst_addr, bus.packet_src_addr, bus.packet_payload}, '0);
        check("rst_busy",       W'(busy), '0);
        check("rst_state",      W'(dbg_state), W'(IDLE));
`ifdef UMI_PACK_TX_ALIGN_EN
        check("rst_err",        W'(err), '0);
`endif
        nreset = 1'b1;
        @(posedge clk); #1;

        // read: one packet at T+1, payload zero
        send_hdr(8'h02, 4'd6, 20'($urandom()), 64'h1000, {$urandom(), $urandom()});
        @(negedge clk);
        check("rd_latency", W'(bus.packet_valid), W'(1));
        check("rd_busy",    W'(busy), W'(1));
        @(posedge clk); #1;

        // 4-beat write, one packet per cycle
        send_hdr(8'h01, 4'd7, 20'($urandom()), 64'h2000, {$urandom(), $urandom()});
        send_beats(4, 1'b0, stalls);
        check("burst_throughput", W'(stalls), '0);

        // same burst under toggling backpressure
        ready_mode = 1;
        send_hdr(8'h01, 4'd7, 20'($urandom()), 64'h2000, {$urandom(), $urandom()});
        send_beats(4, 1'b0, stalls);
        ready_mode = 0;

        // destination address wraps to zero on the third packet
        send_hdr(8'h01, 4'd7, 20'($urandom()), 64'hFFFF_FFFF_FFFF_FFC0, {$urandom(), $urandom()});
        send_beats(4, 1'b0, stalls);

        // partial write
        send_hdr(8'h01, 4'd2, 20'($urandom()), 64'h4, {$urandom(), $urandom()});
        send_beats(1, 1'b0, stalls);
        wait_drain();

        // reset mid-burst after beat 2 of 4
        send_hdr(8'h01, 4'd7, 20'($urandom()), 64'h3000, {$urandom(), $urandom()});
        send_beats(2, 1'b1, stalls);
        nreset = 1'b0;
        #1;
        check("mid_rst_valid",  W'(bus.packet_valid), '0);
        check("mid_rst_fields", {bus.packet_cmd, bus.packet_dst_addr, bus.packet_src_addr, bus.packet_payload}, '0);
        check("mid_rst_ready",  W'({bus.req_ready, bus.data_ready}), W'(2'b10));
        check("mid_rst_busy",   W'(busy), '0);
        exp_q.delete();
        bus.data_valid = 1'b0;
        #2 nreset = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", W'({bus.packet_valid, dbg_state}), W'({1'b0, IDLE}));
            @(posedge clk); #1;
        end
        send_hdr(8'h02, 4'd3, 20'($urandom()), 64'h5000, {$urandom(), $urandom()});
        wait_drain();

`ifdef UMI_PACK_TX_ALIGN_EN
        // misaligned write dropped with an err pulse
        send_hdr(8'h01, 4'd5, 20'($urandom()), 64'h10, {$urandom(), $urandom()});
        @(negedge clk);
        check("align_err",    W'(err), W'(1));
        check("align_quiet",  W'({bus.packet_valid, bus.data_ready, dbg_state}), '0);
        @(posedge clk); #1;
        @(negedge clk);
        check("align_pulse",  W'(err), '0);
        @(posedge clk); #1;
`endif

        // randomized requests under random backpressure
        for (int r = 0; r < 24; r++) begin
            op  = 8'($urandom());
            ts  = 4'($urandom_range(0, 8));
            lg  = (int'(ts) > PB) ? PB : int'(ts);
            dst = {$urandom(), $urandom()};
            dst = dst & ~((64'd1 << lg) - 64'd1);
            ready_mode = $urandom_range(0, 2);
            send_hdr(op, ts, 20'($urandom()), dst, {$urandom(), $urandom()});
            if (op[0]) send_beats(model_beats(op, ts), 1'b0, stalls);
        end
        ready_mode = 0;
        wait_drain();
        check("end_busy", W'(busy), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
